// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and the requester bundle used by the register-file
// write arbiter.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef struct packed {
      logic     valid;
      regbits_t wsel;
      word_t    wdat;
   } rf_req_t;

   typedef enum logic {
      PRIO_REQ0 = 1'b0,
      PRIO_REQ1 = 1'b1
   } prio_t;

   localparam regbits_t REG_ZERO = '0;

   // r0 is hardwired to zero, so a transfer addressed to it never asserts WEN.
   function automatic logic is_live_write(input logic xfer, input regbits_t wsel);
      return xfer && (wsel != REG_ZERO);
   endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundles the requester handshakes, register-file write port, hazard and
// counter signals of the write arbiter.
interface rf_write_arbiter_if #(
   parameter int unsigned CNT_W = 16
);
   import cpu_types_pkg::*;

   logic             hold;
   logic             req0_valid;
   regbits_t         req0_wsel;
   word_t            req0_wdat;
   logic             req0_ready;
   logic             req1_valid;
   regbits_t         req1_wsel;
   word_t            req1_wdat;
   logic             req1_ready;
   logic             rf_WEN;
   regbits_t         rf_wsel;
   word_t            rf_wdat;
   regbits_t         rsel1;
   regbits_t         rsel2;
   logic             hazard1;
   logic             hazard2;
   word_t            fwd_dat;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   modport master (
      output hold,
      output req0_valid, req0_wsel, req0_wdat,
      input  req0_ready,
      output req1_valid, req1_wsel, req1_wdat,
      input  req1_ready,
      input  rf_WEN, rf_wsel, rf_wdat,
      output rsel1, rsel2,
      input  hazard1, hazard2, fwd_dat,
      input  cnt0, cnt1
   );

   modport slave (
      input  hold,
      input  req0_valid, req0_wsel, req0_wdat,
      output req0_ready,
      input  req1_valid, req1_wsel, req1_wdat,
      output req1_ready,
      output rf_WEN, rf_wsel, rf_wdat,
      input  rsel1, rsel2,
      output hazard1, hazard2, fwd_dat,
      output cnt0, cnt1
   );

endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-input round-robin grant with a registered priority pointer; the pointer
// only moves after a contended cycle that produced a grant.
module rr_arb2
   import cpu_types_pkg::*;
#(
   parameter int unsigned RESET_PRIO = 0
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       hold,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   localparam prio_t PRIO_INIT = (RESET_PRIO == 0) ? PRIO_REQ0 : PRIO_REQ1;

   prio_t prio, prio_nxt;

   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         prio <= PRIO_INIT;
      end else begin
         prio <= prio_nxt;
      end
   end

   always_comb begin
      gnt      = '0;
      prio_nxt = prio;
      if (!hold) begin
         unique case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
               if (prio == PRIO_REQ0) begin
                  gnt      = 2'b01;
                  prio_nxt = PRIO_REQ1;
               end else begin
                  gnt      = 2'b10;
                  prio_nxt = PRIO_REQ0;
               end
            end
            default: gnt = '0;
         endcase
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the WB stage (req0) and the
// multicycle unit (req1): round-robin grant, one registered write per cycle.
module rf_write_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned RESET_PRIO = 0
) (
   input  logic                CLK,
   input  logic                nRST,
   rf_write_arbiter_if.slave   bus
);

   rf_req_t          req0, req1, win;
   logic [1:0]       gnt;
   logic             xfer;
   logic             wen_q;
   regbits_t         wsel_q;
   word_t            wdat_q;
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   assign req0 = '{valid: bus.req0_valid, wsel: bus.req0_wsel, wdat: bus.req0_wdat};
   assign req1 = '{valid: bus.req1_valid, wsel: bus.req1_wsel, wdat: bus.req1_wdat};

   // Reset is folded into hold so no ready can rise while reset is asserted.
   rr_arb2 #(
      .RESET_PRIO(RESET_PRIO)
   ) u_arb (
      .CLK  (CLK),
      .nRST (nRST),
      .hold (bus.hold | nRST),
      .req  ({req1.valid, req0.valid}),
      .gnt  (gnt)
   );

   assign bus.req0_ready = gnt[0];
   assign bus.req1_ready = gnt[1];
   assign xfer           = |gnt;

   always_comb begin
      win = req0;
      if (gnt[1]) begin
         win = req1;
      end
   end

   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         wen_q  <= 1'b0;
         wsel_q <= '0;
         wdat_q <= '0;
      end else begin
         wen_q <= is_live_write(xfer, win.wsel);
         if (xfer) begin
            wsel_q <= win.wsel;
            wdat_q <= win.wdat;
         end
      end
   end

   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (gnt[0] && (cnt0_q != '1)) begin
            cnt0_q <= cnt0_q + CNT_W'(1);
         end
         if (gnt[1] && (cnt1_q != '1)) begin
            cnt1_q <= cnt1_q + CNT_W'(1);
         end
      end
   end

   assign bus.rf_WEN  = wen_q;
   assign bus.rf_wsel = wsel_q;
   assign bus.rf_wdat = wdat_q;
   assign bus.fwd_dat = wdat_q;
   assign bus.cnt0    = cnt0_q;
   assign bus.cnt1    = cnt1_q;

   assign bus.hazard1 = wen_q && (wsel_q == bus.rsel1) && (bus.rsel1 != REG_ZERO);
   assign bus.hazard2 = wen_q && (wsel_q == bus.rsel2) && (bus.rsel2 != REG_ZERO);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a randomized
// run against a cycle-level reference model of the arbitration rules.
module tb_rf_write_arbiter;
   import cpu_types_pkg::*;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   rf_write_arbiter_if #(.CNT_W(16)) bm ();
   rf_write_arbiter_if #(.CNT_W(2))  bs ();

   assign bs.hold       = bm.hold;
   assign bs.req0_valid = bm.req0_valid;
   assign bs.req0_wsel  = bm.req0_wsel;
   assign bs.req0_wdat  = bm.req0_wdat;
   assign bs.req1_valid = bm.req1_valid;
   assign bs.req1_wsel  = bm.req1_wsel;
   assign bs.req1_wdat  = bm.req1_wdat;
   assign bs.rsel1      = bm.rsel1;
   assign bs.rsel2      = bm.rsel2;

   rf_write_arbiter #(.CNT_W(16), .RESET_PRIO(0)) dut   (.CLK(CLK), .nRST(nRST), .bus(bm.slave));
   rf_write_arbiter #(.CNT_W(2),  .RESET_PRIO(0)) dut_s (.CLK(CLK), .nRST(nRST), .bus(bs.slave));

   int checks = 0;
   int errors = 0;

   // Reference model: favoured requester, expected write-port contents, and
   // unbounded transfer counts (saturation applied when comparing).
   int          m_fav;
   logic        m_wen;
   logic [4:0]  m_wsel;
   logic [31:0] m_wdat;
   int          m_c0, m_c1;

   function automatic logic [1:0] exp_gnt();
      if (nRST || bm.hold) return 2'b00;
      if (bm.req0_valid && bm.req1_valid) return (m_fav == 0) ? 2'b01 : 2'b10;
      return {bm.req1_valid, bm.req0_valid};
   endfunction

   function automatic int sat(input int c, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (c > mx) ? mx : c;
   endfunction

   task automatic model_reset();
      m_fav = 0; m_wen = 1'b0; m_wsel = '0; m_wdat = '0; m_c0 = 0; m_c1 = 0;
   endtask

   task automatic tick();
      logic [1:0]  g;
      logic        both;
      logic [4:0]  s;
      logic [31:0] d;
      g    = exp_gnt();
      both = bm.req0_valid && bm.req1_valid;
      s    = g[1] ? bm.req1_wsel : bm.req0_wsel;
      d    = g[1] ? bm.req1_wdat : bm.req0_wdat;
      @(posedge CLK);
      if (nRST) begin
         model_reset();
      end else if (g != 2'b00) begin
         m_wen  = (s != 5'd0);
         m_wsel = s;
         m_wdat = d;
         if (g[0]) m_c0++;
         if (g[1]) m_c1++;
         if (both) m_fav = g[0] ? 1 : 0;
      end else begin
         m_wen = 1'b0;
      end
      #1;
   endtask

   task automatic drive_idle();
      bm.hold = 1'b0;
      bm.req0_valid = 1'b0; bm.req0_wsel = '0; bm.req0_wdat = '0;
      bm.req1_valid = 1'b0; bm.req1_wsel = '0; bm.req1_wdat = '0;
      bm.rsel1 = '0; bm.rsel2 = '0;
   endtask

   task automatic apply_reset();
      nRST = 1'b1;
      drive_idle();
      model_reset();
      tick();
      tick();
      nRST = 1'b0;
   endtask

   task automatic test_reset();
      nRST = 1'b1;
      drive_idle();
      model_reset();
      bm.req0_valid = 1'b1; bm.req1_valid = 1'b1;
      #1;
      checks++; if (bm.req0_ready !== 1'b0 || bm.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", bm.req1_ready, bm.req0_ready); end
      checks++; if (bm.rf_WEN !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", bm.rf_WEN); end
      checks++; if (bm.rf_wsel !== 5'd0 || bm.rf_wdat !== 32'd0) begin errors++; $display("FAIL reset_wdata got %0d/%h exp 0/0", bm.rf_wsel, bm.rf_wdat); end
      checks++; if (bm.cnt0 !== 16'd0 || bm.cnt1 !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", bm.cnt0, bm.cnt1); end
      tick();
      tick();
      nRST = 1'b0;
      drive_idle();
      #1;
      checks++; if (bm.req0_ready !== 1'b0 || bm.req1_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b%b exp 00", bm.req1_ready, bm.req0_ready); end
      tick();
      checks++; if (bm.rf_WEN !== 1'b0 || bm.cnt0 !== 16'd0 || bm.cnt1 !== 16'd0) begin errors++; $display("FAIL idle_state got wen=%b c0=%0d c1=%0d exp 0/0/0", bm.rf_WEN, bm.cnt0, bm.cnt1); end
   endtask

   task automatic test_single();
      apply_reset();
      bm.req0_valid = 1'b1; bm.req0_wsel = 5'd5; bm.req0_wdat = 32'hDEADBEEF;
      #1;
      checks++; if (bm.req0_ready !== 1'b1 || bm.req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b%b exp 01", bm.req1_ready, bm.req0_ready); end
      tick();
      bm.req0_valid = 1'b0;
      #1;
      checks++; if (bm.rf_WEN !== 1'b1 || bm.rf_wsel !== 5'd5 || bm.rf_wdat !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write got %b/%0d/%h exp 1/5/deadbeef", bm.rf_WEN, bm.rf_wsel, bm.rf_wdat); end
      checks++; if (bm.cnt0 !== 16'd1 || bm.cnt1 !== 16'd0) begin errors++; $display("FAIL single_cnt got %0d/%0d exp 1/0", bm.cnt0, bm.cnt1); end
      tick();
      checks++; if (bm.rf_WEN !== 1'b0 || bm.rf_wsel !== 5'd5) begin errors++; $display("FAIL single_after got %b/%0d exp 0/5", bm.rf_WEN, bm.rf_wsel); end
   endtask

   task automatic test_contention();
      apply_reset();
      bm.req0_valid = 1'b1; bm.req0_wsel = 5'd1; bm.req0_wdat = 32'h1111_0000;
      bm.req1_valid = 1'b1; bm.req1_wsel = 5'd2; bm.req1_wdat = 32'h2222_0000;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (bm.req0_ready !== ((i % 2) == 0) || bm.req1_ready !== ((i % 2) == 1)) begin errors++; $display("FAIL contend_gnt%0d got %b%b", i, bm.req1_ready, bm.req0_ready); end
         if (i > 0) begin
            checks++; if (bm.rf_WEN !== 1'b1 || bm.rf_wsel !== ((((i - 1) % 2) == 0) ? 5'd1 : 5'd2)) begin errors++; $display("FAIL contend_wsel%0d got %b/%0d", i, bm.rf_WEN, bm.rf_wsel); end
         end
         tick();
      end
      drive_idle();
      #1;
      checks++; if (bm.rf_WEN !== 1'b1 || bm.rf_wsel !== 5'd2 || bm.rf_wdat !== 32'h2222_0000) begin errors++; $display("FAIL contend_last got %b/%0d/%h exp 1/2/22220000", bm.rf_WEN, bm.rf_wsel, bm.rf_wdat); end
      checks++; if (bm.cnt0 !== 16'd2 || bm.cnt1 !== 16'd2) begin errors++; $display("FAIL contend_cnt got %0d/%0d exp 2/2", bm.cnt0, bm.cnt1); end
   endtask

   task automatic test_r0_hold();
      apply_reset();
      bm.req1_valid = 1'b1; bm.req1_wsel = 5'd0; bm.req1_wdat = 32'h0000_1234;
      #1;
      checks++; if (bm.req1_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b exp 1", bm.req1_ready); end
      tick();
      bm.req1_valid = 1'b0;
      #1;
      checks++; if (bm.rf_WEN !== 1'b0 || bm.rf_wdat !== 32'h0000_1234 || bm.cnt1 !== 16'd1) begin errors++; $display("FAIL r0_write got wen=%b dat=%h c1=%0d exp 0/1234/1", bm.rf_WEN, bm.rf_wdat, bm.cnt1); end
      bm.hold = 1'b1;
      bm.req0_valid = 1'b1; bm.req0_wsel = 5'd3; bm.req0_wdat = 32'hCAFE_0003;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bm.req0_ready !== 1'b0) begin errors++; $display("FAIL hold_ready%0d got %b exp 0", i, bm.req0_ready); end
         tick();
      end
      bm.hold = 1'b0;
      #1;
      checks++; if (bm.req0_ready !== 1'b1 || bm.cnt0 !== 16'd0) begin errors++; $display("FAIL hold_release got %b c0=%0d exp 1/0", bm.req0_ready, bm.cnt0); end
      tick();
      bm.req0_valid = 1'b0;
      #1;
      checks++; if (bm.rf_WEN !== 1'b1 || bm.rf_wsel !== 5'd3 || bm.cnt0 !== 16'd1) begin errors++; $display("FAIL hold_write got %b/%0d c0=%0d exp 1/3/1", bm.rf_WEN, bm.rf_wsel, bm.cnt0); end
   endtask

   task automatic test_hazard();
      apply_reset();
      bm.req0_valid = 1'b1; bm.req0_wsel = 5'd7; bm.req0_wdat = 32'hA5A5A5A5;
      #1;
      tick();
      bm.req0_valid = 1'b0;
      bm.rsel1 = 5'd7; bm.rsel2 = 5'd0;
      #1;
      checks++; if (bm.hazard1 !== 1'b1 || bm.hazard2 !== 1'b0) begin errors++; $display("FAIL hazard_a got %b%b exp 10", bm.hazard1, bm.hazard2); end
      checks++; if (bm.fwd_dat !== 32'hA5A5A5A5) begin errors++; $display("FAIL hazard_fwd got %h exp a5a5a5a5", bm.fwd_dat); end
      bm.rsel1 = 5'd3; bm.rsel2 = 5'd7;
      #1;
      checks++; if (bm.hazard1 !== 1'b0 || bm.hazard2 !== 1'b1) begin errors++; $display("FAIL hazard_b got %b%b exp 01", bm.hazard1, bm.hazard2); end
      tick();
      bm.rsel1 = 5'd7;
      #1;
      checks++; if (bm.hazard1 !== 1'b0 || bm.hazard2 !== 1'b0) begin errors++; $display("FAIL hazard_stale got %b%b exp 00", bm.hazard1, bm.hazard2); end
   endtask

   task automatic test_saturation();
      apply_reset();
      bm.req0_valid = 1'b1; bm.req0_wsel = 5'd4; bm.req0_wdat = 32'h0000_0044;
      repeat (5) tick();
      bm.req0_valid = 1'b0;
      #1;
      checks++; if (bs.cnt0 !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d exp 3", bs.cnt0); end
      checks++; if (bm.cnt0 !== 16'd5) begin errors++; $display("FAIL sat_cnt16 got %0d exp 5", bm.cnt0); end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      bm.req0_valid = 1'b1; bm.req0_wsel = 5'd9; bm.req0_wdat = 32'h9999_9999;
      #1;
      tick();
      bm.req0_valid = 1'b0;
      #1;
      checks++; if (bm.rf_WEN !== 1'b1) begin errors++; $display("FAIL midrst_staged got %b exp 1", bm.rf_WEN); end
      nRST = 1'b1;
      model_reset();
      #1;
      checks++; if (bm.rf_WEN !== 1'b0 || bm.rf_wsel !== 5'd0 || bm.cnt0 !== 16'd0) begin errors++; $display("FAIL midrst_async got %b/%0d c0=%0d exp 0/0/0", bm.rf_WEN, bm.rf_wsel, bm.cnt0); end
      tick();
      nRST = 1'b0;
      #1;
      tick();
      checks++; if (bm.rf_WEN !== 1'b0) begin errors++; $display("FAIL midrst_release got %b exp 0", bm.rf_WEN); end
      // Offer a write, then pull reset before the edge that would have staged it.
      bm.req0_valid = 1'b1; bm.req0_wsel = 5'd11; bm.req0_wdat = 32'hBBBB_0011;
      #1;
      checks++; if (bm.req0_ready !== 1'b1) begin errors++; $display("FAIL midrst_offer got %b exp 1", bm.req0_ready); end
      nRST = 1'b1;
      model_reset();
      #1;
      checks++; if (bm.req0_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", bm.req0_ready); end
      tick();
      nRST = 1'b0;
      bm.req0_valid = 1'b0;
      #1;
      tick();
      checks++; if (bm.rf_WEN !== 1'b0 || bm.cnt0 !== 16'd0) begin errors++; $display("FAIL midrst_discard got %b c0=%0d exp 0/0", bm.rf_WEN, bm.cnt0); end
   endtask

   task automatic test_random();
      logic [1:0] g;
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         if (!bm.req0_valid && ($urandom % 3 == 0)) begin
            bm.req0_valid = 1'b1; bm.req0_wsel = 5'($urandom % 8); bm.req0_wdat = $urandom;
         end
         if (!bm.req1_valid && ($urandom % 3 == 0)) begin
            bm.req1_valid = 1'b1; bm.req1_wsel = 5'($urandom % 8); bm.req1_wdat = $urandom;
         end
         bm.hold  = ($urandom % 6 == 0);
         bm.rsel1 = 5'($urandom % 8);
         bm.rsel2 = 5'($urandom % 8);
         #1;
         g = exp_gnt();
         checks++; if ({bm.req1_ready, bm.req0_ready} !== g) begin errors++; $display("FAIL rnd_gnt n=%0d got %b%b exp %b", n, bm.req1_ready, bm.req0_ready, g); end
         checks++; if (bm.rf_WEN !== m_wen || bm.rf_wsel !== m_wsel || bm.rf_wdat !== m_wdat) begin errors++; $display("FAIL rnd_wport n=%0d got %b/%0d/%h exp %b/%0d/%h", n, bm.rf_WEN, bm.rf_wsel, bm.rf_wdat, m_wen, m_wsel, m_wdat); end
         checks++; if (bm.fwd_dat !== m_wdat) begin errors++; $display("FAIL rnd_fwd n=%0d got %h exp %h", n, bm.fwd_dat, m_wdat); end
         checks++; if (bm.hazard1 !== (m_wen && m_wsel == bm.rsel1 && bm.rsel1 != 5'd0) || bm.hazard2 !== (m_wen && m_wsel == bm.rsel2 && bm.rsel2 != 5'd0)) begin errors++; $display("FAIL rnd_hazard n=%0d got %b%b", n, bm.hazard1, bm.hazard2); end
         checks++; if (int'(bm.cnt0) !== sat(m_c0, 16) || int'(bm.cnt1) !== sat(m_c1, 16)) begin errors++; $display("FAIL rnd_cnt16 n=%0d got %0d/%0d exp %0d/%0d", n, bm.cnt0, bm.cnt1, sat(m_c0, 16), sat(m_c1, 16)); end
         checks++; if (int'(bs.cnt0) !== sat(m_c0, 2) || int'(bs.cnt1) !== sat(m_c1, 2)) begin errors++; $display("FAIL rnd_cnt2 n=%0d got %0d/%0d exp %0d/%0d", n, bs.cnt0, bs.cnt1, sat(m_c0, 2), sat(m_c1, 2)); end
         tick();
         if (g[0]) bm.req0_valid = 1'b0;
         if (g[1]) bm.req1_valid = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_r0_hold();
      test_hazard();
      test_saturation();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters.
  - Requester 0: pipeline WB stage.
  - Requester 1: multicycle unit (divider / late load return).
- Valid/ready handshake on each requester.
- Round-robin arbitration, one accepted write per cycle, registered write stage driving the register file's WEN/wsel/wdat.
- Also flags read-after-write hazards against the in-flight write, and keeps per-requester accepted-write counters.

Parameters:
- CNT_W, 16, width of each saturating accepted-write counter.
- RESET_PRIO, 0, requester favoured on first contention after reset (0 or 1).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  reset; asynchronous, active-high (asserted = 1).
- hold  input  1  when 1, no requester is granted (flush/stall).
- req0_valid  input  1  requester 0 has a write.
- req0_wsel  input  5  requester 0 destination register.
- req0_wdat  input  32  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle.
- req1_valid  input  1  requester 1 has a write.
- req1_wsel  input  5  requester 1 destination register.
- req1_wdat  input  32  requester 1 write data.
- req1_ready  output  1  requester 1 write accepted this cycle.
- rf_WEN  output  1  register file write enable.
- rf_wsel  output  5  register file write select.
- rf_wdat  output  32  register file write data.
- rsel1  input  5  read select 1 (mirrors register file port).
- rsel2  input  5  read select 2.
- hazard1  output  1  rsel1 targets the write landing this cycle.
- hazard2  output  1  rsel2 targets the write landing this cycle.
- fwd_dat  output  32  forwarding value; always equals rf_wdat.
- cnt0  output  CNT_W  accepted writes from requester 0, saturating.
- cnt1  output  CNT_W  accepted writes from requester 1, saturating.

Behaviour:
- Reset (nRST=1, async):
  - Outputs: rf_WEN=0, rf_wsel=0, rf_wdat=0, cnt0=cnt1=0.
  - Internal: prio=RESET_PRIO.
  - req0_ready=req1_ready=0 while nRST=1.
  - Reset mid-transfer discards the staged write; rf_WEN is 0 the cycle after deassertion.
- Transfer: occurs when reqN_valid && reqN_ready.
  - Requesters must hold valid, wsel and wdat stable until accepted. The arbiter never withdraws a grant within a cycle.
- Grant (combinational):
  - hold=1 → no grant.
  - Exactly one valid → grant it.
  - Both valid → grant requester prio.
  - At most one ready high per cycle; ready never high without matching valid.
- prio update (registered): after any cycle where both were valid and one was granted, prio ← the other requester. Otherwise unchanged.
- Write stage (1-cycle latency):
  - Transfer in cycle T with wsel≠0 → in cycle T+1: rf_WEN=1, rf_wsel=wsel, rf_wdat=wdat.
  - Transfer with wsel=0 is accepted and counted, but rf_WEN=0 in T+1 (r0 immutable). rf_wsel/rf_wdat still load.
  - No transfer → rf_WEN=0 next cycle; rf_wsel/rf_wdat hold.
  - Back-to-back transfers produce back-to-back writes; no bubble inserted.
- Same wsel from both requesters in consecutive cycles: both are written in grant order. The later grant wins in the register file.
- Hazards (combinational):
  - hazardN = rf_WEN && (rf_wsel == rselN) && (rselN ≠ 0).
  - Consumers mux fwd_dat when hazardN=1.
- Counters: cntN increments on each requester-N transfer and saturates at all-ones (no wrap). Counting continues regardless of wsel.

Decomposition:
- cpu_types_pkg supplies word_t (32-bit) and regbits_t (5-bit). Ports use these types.
- Add to cpu_types_pkg: typedef rf_req_t {valid, wsel, wdat} for bundling requesters.
- One natural sub-module: rr_arb2. Two-input round-robin grant logic plus the prio flop, with inputs req[1:0] and hold, output gnt[1:0]. Write stage, hazard logic and counters stay in rf_write_arbiter.

Test Plan:
- Reset then idle: nRST=1 for 2 cycles, all valids 0 → rf_WEN=0, cnt0=cnt1=0, both ready=0 through and after reset.
- Single requester: req0 {wsel=5, wdat=0xDEADBEEF} valid 1 cycle → req0_ready=1 same cycle; next cycle rf_WEN=1, rf_wsel=5, rf_wdat=0xDEADBEEF; cnt0=1.
- Contention, RESET_PRIO=0: both valid for 4 cycles, req0 wsel=1 and req1 wsel=2 throughout → grants 0,1,0,1; rf_wsel sequence 1,2,1,2 one cycle later; cnt0=cnt1=2.
- r0 write and hold: req1 wsel=0 wdat=0x1234 accepted → next cycle rf_WEN=0, cnt1 increments. Then hold=1 with req0 valid → req0_ready=0 until hold=0.
- Hazard: req0 {wsel=7, wdat=0xA5A5A5A5} accepted, next cycle rsel1=7, rsel2=0 → hazard1=1, hazard2=0, fwd_dat=0xA5A5A5A5.
- Saturation and mid-reset: CNT_W=2, req0 valid 5 cycles → cnt0 stops at 3. Assert nRST while a write is staged → rf_WEN drops immediately, no write after release.
